// File: rtl/instr_ctrl_pkg.sv
// Shared opcode/state encodings, instruction field positions and decode helpers
// for the instr_ctrl multicycle instruction controller.
package instr_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_HALT = 4'h0,
    OP_XOR  = 4'h1,
    OP_BNEZ = 4'h2,
    OP_ADD  = 4'h3,
    OP_LSH  = 4'h4,
    OP_RSH  = 4'h5,
    OP_MOVB = 4'h6,
    OP_NOP  = 4'h7,
    OP_PARI = 4'h8,
    OP_LDR  = 4'h9,
    OP_OR   = 4'hA,
    OP_SUB  = 4'hB,
    OP_STR  = 4'hC
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_WB,
    ST_HALTED
  } state_e;

  localparam int INSTR_W = 9;
  localparam int OP_MSB  = 8;
  localparam int OP_LSB  = 5;
  localparam int RA_MSB  = 4;
  localparam int RA_LSB  = 2;
  localparam int RB_MSB  = 1;
  localparam int RB_LSB  = 0;
  localparam int IDX_MSB = 4;

  function automatic logic [3:0] alu_cmd_of(input logic [3:0] op);
    case (op)
      OP_XOR, OP_BNEZ, OP_ADD, OP_LSH, OP_RSH,
      OP_MOVB, OP_PARI, OP_OR, OP_SUB: alu_cmd_of = op;
      OP_LDR, OP_STR:                  alu_cmd_of = OP_MOVB;
      default:                         alu_cmd_of = 4'h0;
    endcase
  endfunction

  function automatic logic writes_rf(input logic [3:0] op);
    case (op)
      OP_XOR, OP_ADD, OP_LSH, OP_RSH, OP_MOVB,
      OP_PARI, OP_OR, OP_SUB, OP_LDR: writes_rf = 1'b1;
      default:                        writes_rf = 1'b0;
    endcase
  endfunction

  // bnez reads R0 on port B so the ALU can test it.
  function automatic logic [2:0] rb_sel(input logic [INSTR_W-1:0] w);
    if (w[OP_MSB:OP_LSB] == OP_BNEZ) rb_sel = 3'd0;
    else                             rb_sel = {1'b0, w[RB_MSB:RB_LSB]};
  endfunction

endpackage

// File: rtl/instr_ctrl_branch_lut.sv
// Constant branch-target table: entry i holds (13*i + 1) mod 2^PC_W, read combinationally.
module branch_lut #(
  parameter int PC_W   = 10,
  parameter int LUT_AW = 5
) (
  input  logic [LUT_AW-1:0] idx_i,
  output logic [PC_W-1:0]   target_o
);

  assign target_o = PC_W'(32'(idx_i) * 32'd13 + 32'd1);

endmodule

// File: rtl/instr_ctrl.sv
// Four-cycle FETCH/DECODE/EXEC/WB instruction controller with branch LUT.
// Optional run-cycle counter enabled by defining CYCLE_CNT_EN.
module instr_ctrl
  import instr_ctrl_pkg::*;
#(
  parameter int PC_W   = 10,
  parameter int LUT_AW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [8:0]      instr,
  input  logic [7:0]      alu_rslt,
  output logic [PC_W-1:0] prog_ctr,
  output logic [3:0]      alu_cmd,
  output logic [2:0]      rf_raddr_a,
  output logic [2:0]      rf_raddr_b,
  output logic [2:0]      rf_waddr,
  output logic            rf_we,
  output logic            rf_wsel,
  output logic [7:0]      mem_addr,
  output logic            mem_we,
  output logic            done,
  output logic [15:0]     cycle_cnt
);

  state_e              state_q;
  logic [PC_W-1:0]     pc_q;
  logic [INSTR_W-1:0]  ir_q;
  logic [7:0]          rslt_q;
  logic [3:0]          alu_cmd_q;
  logic [2:0]          raddr_a_q, raddr_b_q, waddr_q;
  logic                rf_we_q, wsel_q, mem_we_q, done_q;

  logic [3:0]          op;
  logic [2:0]          ra;
  logic [LUT_AW-1:0]   lut_idx;
  logic [PC_W-1:0]     lut_target;

  assign op      = ir_q[OP_MSB:OP_LSB];
  assign ra      = ir_q[RA_MSB:RA_LSB];
  assign lut_idx = LUT_AW'(ir_q[IDX_MSB:0]);

  branch_lut #(.PC_W(PC_W), .LUT_AW(LUT_AW)) u_branch_lut (
    .idx_i    (lut_idx),
    .target_o (lut_target)
  );

  // All outputs are registered; per-cycle strobes default low every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      rslt_q    <= '0;
      alu_cmd_q <= '0;
      raddr_a_q <= '0;
      raddr_b_q <= '0;
      waddr_q   <= '0;
      rf_we_q   <= 1'b0;
      wsel_q    <= 1'b0;
      mem_we_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      alu_cmd_q <= '0;
      raddr_a_q <= '0;
      raddr_b_q <= '0;
      waddr_q   <= '0;
      rf_we_q   <= 1'b0;
      wsel_q    <= 1'b0;
      mem_we_q  <= 1'b0;
      case (state_q)
        ST_IDLE, ST_HALTED: begin
          if (start) begin
            state_q <= ST_FETCH;
            pc_q    <= '0;
            done_q  <= 1'b0;
          end
        end
        ST_FETCH: begin
          ir_q      <= instr;
          raddr_a_q <= instr[RA_MSB:RA_LSB];
          raddr_b_q <= rb_sel(instr);
          state_q   <= ST_DECODE;
        end
        ST_DECODE: begin
          if (op == OP_HALT) begin
            state_q <= ST_HALTED;
            done_q  <= 1'b1;
          end else begin
            raddr_a_q <= ra;
            raddr_b_q <= rb_sel(ir_q);
            alu_cmd_q <= alu_cmd_of(op);
            state_q   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rslt_q   <= alu_rslt;
          rf_we_q  <= writes_rf(op);
          wsel_q   <= (op == OP_LDR);
          mem_we_q <= (op == OP_STR);
          waddr_q  <= ra;
          state_q  <= ST_WB;
        end
        ST_WB: begin
          pc_q    <= (op == OP_BNEZ && rslt_q[0]) ? lut_target : pc_q + PC_W'(1);
          state_q <= ST_FETCH;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign prog_ctr   = pc_q;
  assign alu_cmd    = alu_cmd_q;
  assign rf_raddr_a = raddr_a_q;
  assign rf_raddr_b = raddr_b_q;
  assign rf_waddr   = waddr_q;
  assign rf_we      = rf_we_q;
  assign rf_wsel    = wsel_q;
  assign mem_addr   = rslt_q;
  assign mem_we     = mem_we_q;
  assign done       = done_q;

`ifdef CYCLE_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Counts edges into a run state; the halt's DECODE->HALTED edge is not one.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_IDLE || state_q == ST_HALTED) begin
      if (start) cnt_d = '0;
    end else if (!(state_q == ST_DECODE && op == OP_HALT) && cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cycle_cnt = cnt_q;
`else
  assign cycle_cnt = '0;
`endif

endmodule
